// File: rtl/spi_jetson_bridge.sv
// SPI (mode 0, MSB first) slave bridging a host to core-side TX/RX word FIFOs with a status word.
// Optional status shadow register enabled by defining SPI_SHADOW_STATUS_EN.
module spi_jetson_bridge #(
  parameter int WORD_W     = 32,
  parameter int TAG_W      = 4,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [1:0]        gpio_wr_status,
  output logic [1:0]        gpio_rd_status,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_din,
  output logic              wr_full,
  input  logic              rd_en,
  output logic              rd_rdy,
  output logic [WORD_W-1:0] rd_dout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam int SH_W  = WORD_W - TAG_W - 3;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2+1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0] AE_CNT   = (DEPTH_LOG2+1)'(AE_LEVEL);
  localparam logic [CNT_W-1:0]    BITS_W   = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0]    BITS_SAT = CNT_W'(WORD_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  // ---------------- synchronisers and edge detection ----------------
  logic [1:0] sck_s, mosi_s, cs_s;
  logic       sck_q, cs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s  <= '0;
      mosi_s <= '0;
      cs_s   <= '1;
      sck_q  <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sck_s  <= {sck_s[0], spi_clk};
      mosi_s <= {mosi_s[0], spi_mosi};
      cs_s   <= {cs_s[0], spi_cs};
      sck_q  <= sck_s[1];
      cs_q   <= cs_s[1];
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_s[1] & ~sck_q;
  assign sck_fall = ~sck_s[1] & sck_q;
  assign cs_fall  = ~cs_s[1] & cs_q;
  assign cs_rise  = cs_s[1] & ~cs_q;

  // ---------------- frame FSM ----------------
  state_t state, state_n;
  logic   do_start, do_load, do_end, in_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_load  = 1'b0;
    do_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          do_start = 1'b1;
          state_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        do_load = 1'b1;
        if (cs_rise) begin
          do_end  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          do_end  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign in_frame = (state != ST_IDLE);

  // ---------------- TX FIFO (core -> host) ----------------
  logic [WORD_W-1:0]     tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [DEPTH_LOG2:0]   tx_cnt;
  logic                  tx_empty, tx_full, tx_push, tx_pop, core_data;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_pop   = do_load & ~tx_empty;

`ifdef SPI_SHADOW_STATUS_EN
  logic [SH_W-1:0] shadow;
  logic            wr_tag0;
  assign wr_tag0   = (wr_din[WORD_W-1 -: TAG_W] == '0);
  assign core_data = wr_en & ~wr_tag0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 shadow <= '0;
    else if (wr_en && wr_tag0)  shadow <= wr_din[SH_W-1:0];
  end
`else
  logic [SH_W-1:0] shadow;
  assign core_data = wr_en;
  assign shadow    = '0;
`endif

  assign tx_push = core_data & (~tx_full | tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------- shift registers and bit counter ----------------
  logic [WORD_W-1:0] tx_shift, rx_shift, status_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tx_is_status, overflow, frame_err;

  assign status_word = {{TAG_W{1'b0}}, overflow, frame_err, tx_empty, shadow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift     <= '0;
      tx_is_status <= 1'b0;
    end else if (do_load) begin
      tx_shift     <= tx_empty ? status_word : tx_mem[tx_rp];
      tx_is_status <= tx_empty;
    end else if (in_frame && sck_fall) begin
      tx_shift     <= {tx_shift[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (do_start) begin
      bit_cnt  <= '0;
    end else if (in_frame && sck_rise) begin
      rx_shift <= {rx_shift[WORD_W-2:0], mosi_s[1]};
      if (bit_cnt != BITS_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // ---------------- RX FIFO (host -> core) ----------------
  logic [WORD_W-1:0]     rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [DEPTH_LOG2:0]   rx_cnt;
  logic                  rx_empty, rx_full, rx_push, rx_pop, rx_want, complete;
  logic                  ovf_set, ferr_set, flag_clr;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_pop   = rd_en & ~rx_empty;
  assign complete = do_end & (bit_cnt == BITS_W);
  assign rx_want  = complete & (rx_shift[WORD_W-1 -: TAG_W] != '0);
  assign rx_push  = rx_want & (~rx_full | rx_pop);
  assign ovf_set  = rx_want & rx_full & ~rx_pop;
  assign ferr_set = do_end & ~complete;
  assign flag_clr = complete & tx_is_status;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // A flag raised by the same cs rise that would clear it stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set  | (overflow  & ~flag_clr);
      frame_err <= ferr_set | (frame_err & ~flag_clr);
    end
  end

  // ---------------- outputs ----------------
  assign spi_miso       = tx_shift[WORD_W-1];
  assign wr_full        = tx_full;
  assign rd_rdy         = ~rx_empty;
  assign rd_dout        = rx_empty ? '0 : rx_mem[rx_rp];
  assign gpio_wr_status = {(rx_cnt <= AE_CNT) | rx_full, (rx_cnt >= AF_CNT) | rx_full};
  assign gpio_rd_status = {(tx_cnt <= AE_CNT) | tx_empty, (tx_cnt >= AF_CNT) | tx_empty};

endmodule

// File: tb/tb_spi_jetson_bridge.sv
// Scoreboard bench for spi_jetson_bridge: directed host/core transfers, monitors compare RX words and MISO words.
`timescale 1ns/1ps
module tb_spi_jetson_bridge;
  localparam int W    = 32;
  localparam int HALF = 50;

  logic            clk = 1'b0;
  logic            rst_n, spi_clk, spi_mosi, spi_cs, spi_miso;
  logic [1:0]      gpio_wr_status, gpio_rd_status;
  logic            wr_en, wr_full, rd_en, rd_rdy;
  logic [W-1:0]    wr_din, rd_dout;

  int              errors = 0;
  int              checks = 0;
  logic [63:0]     exp_miso[$];
  logic [63:0]     got_miso[$];
  logic [W-1:0]    exp_rx[$];
  bit              rx_drain = 1'b0;

  always #5 clk = ~clk;

  spi_jetson_bridge #(
    .WORD_W(W), .TAG_W(4), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .gpio_wr_status(gpio_wr_status), .gpio_rd_status(gpio_rd_status),
    .wr_en(wr_en), .wr_din(wr_din), .wr_full(wr_full),
    .rd_en(rd_en), .rd_rdy(rd_rdy), .rd_dout(rd_dout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RX monitor: compares and pops the FWFT head whenever draining is enabled.
  initial begin : rx_mon
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_drain && rd_rdy) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected none", rd_dout);
        end else begin
          chk("rx_word", rd_dout, exp_rx.pop_front());
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  // MISO monitor: compares each word captured by the host against the next expectation.
  initial begin : miso_mon
    logic [63:0] g;
    forever begin
      @(negedge clk);
      while (got_miso.size() > 0) begin
        g = got_miso.pop_front();
        if (exp_miso.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: got 0x%0h expected none", g);
        end else begin
          chk("miso_word", g, exp_miso.pop_front());
        end
      end
    end
  end

  task automatic core_write(input logic [W-1:0] v);
    @(negedge clk);
    wr_en  = 1'b1;
    wr_din = v;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic shift_bits(input logic [63:0] tx, input int nbits, output logic [63:0] rx);
    rx = '0;
    spi_cs = 1'b0;
    #(2*HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      #HALF;
      rx = {rx[62:0], spi_miso};
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic host_xfer(input logic [63:0] tx, input int nbits, input logic [63:0] exp);
    logic [63:0] rx;
    exp_miso.push_back(exp);
    shift_bits(tx, nbits, rx);
    #(2*HALF);
    spi_cs = 1'b1;
    got_miso.push_back(rx);
    #(4*HALF);
  endtask

  task automatic wait_rx_empty();
    int n = 0;
    while ((exp_rx.size() != 0 || rd_rdy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_drain_timeout: got %0d pending expected 0", exp_rx.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},    spi_miso,       1'b0);
    chk({tag, "_wr_full"}, wr_full,        1'b0);
    chk({tag, "_rd_rdy"},  rd_rdy,         1'b0);
    chk({tag, "_rd_dout"}, rd_dout,        '0);
    chk({tag, "_gpio_wr"}, gpio_wr_status, 2'b10);
    chk({tag, "_gpio_rd"}, gpio_rd_status, 2'b11);
  endtask

  initial begin : stim
    logic [63:0] partial;
    rst_n = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1;
    wr_en = 1'b0; wr_din = '0;
    #23;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #100;

    // host write of a tagged word; MISO returns the clean status word
    host_xfer(64'h1234_5678, 32, 64'h0200_0000);
    chk("rx_rdy_after_write", rd_rdy, 1'b1);
    chk("rx_head",            rd_dout, 32'h1234_5678);
    chk("gpio_wr_one",        gpio_wr_status, 2'b10);
    exp_rx.push_back(32'h1234_5678);
    rx_drain = 1'b1;
    wait_rx_empty();
    chk("rx_empty_after_drain", rd_rdy, 1'b0);

    // core word is read back, then status with tx_empty
    core_write(32'hA000_00FF);
    chk("gpio_rd_one", gpio_rd_status, 2'b10);
    host_xfer(64'h0, 32, 64'hA000_00FF);
    host_xfer(64'h0, 32, 64'h0200_0000);
    chk("tag0_not_pushed", rd_rdy, 1'b0);

    // two more data patterns
    exp_rx.push_back(32'hF0F0_0001);
    host_xfer(64'hF0F0_0001, 32, 64'h0200_0000);
    exp_rx.push_back(32'h5A5A_A5A5);
    host_xfer(64'h5A5A_A5A5, 32, 64'h0200_0000);
    wait_rx_empty();

    // overflow: 17 writes into a 16-entry RX FIFO
    rx_drain = 1'b0;
    for (int i = 0; i < 17; i++) begin
      host_xfer(64'h1000_0000 + 64'(i), 32, 64'h0200_0000);
      if (i < 16) exp_rx.push_back(32'h1000_0000 + 32'(i));
    end
    chk("gpio_wr_full", gpio_wr_status, 2'b11);
    host_xfer(64'h0, 32, 64'h0A00_0000);
    host_xfer(64'h0, 32, 64'h0200_0000);
    rx_drain = 1'b1;
    wait_rx_empty();
    chk("gpio_wr_drained", gpio_wr_status, 2'b10);

    // aborted 20-bit transfer: no push, frame_err reported once
    host_xfer(64'h12345, 20, 64'h02000);
    chk("abort_no_push", rd_rdy, 1'b0);
    host_xfer(64'h0, 32, 64'h0600_0000);
    host_xfer(64'h0, 32, 64'h0200_0000);

    // reset in the middle of a transfer after 10 bits
    core_write(32'hB000_0001);
    shift_bits(64'h9876_5432, 10, partial);
    rst_n = 1'b0;
    #30;
    chk_reset_outputs("midreset");
    spi_cs = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;
    chk("post_reset_no_push", rd_rdy, 1'b0);
    host_xfer(64'h0, 32, 64'h0200_0000);

`ifdef SPI_SHADOW_STATUS_EN
    core_write(32'h0000_0ABC);
    chk("shadow_not_in_tx", gpio_rd_status, 2'b11);
    host_xfer(64'h0, 32, 64'h0200_0ABC);
`endif

    #200;
    checks++;
    if (exp_miso.size() != 0 || got_miso.size() != 0) begin
      errors++;
      $display("FAIL miso_pending: got %0d pending expected 0", exp_miso.size() + got_miso.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
